// File: rtl/pc_next_unit.sv
// PC source selector and PC register for the multicycle CPU, with EPC capture,
// target-alignment checking, a sticky bad-select flag and an accepted-write counter.
module pc_next_unit #(
  parameter int                 WIDTH      = 32,
  parameter int                 NUM_SRC    = 5,
  parameter int                 SEL_W      = 3,
  parameter int                 ALIGN_BITS = 2,
  parameter logic [WIDTH-1:0]   RESET_PC   = '0,
  parameter logic [WIDTH-1:0]   EPC_OFFSET = WIDTH'(4),
  parameter int                 CNT_W      = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [SEL_W-1:0]         pc_src,
  input  logic [NUM_SRC*WIDTH-1:0] src_data,
  input  logic                     pc_write,
  input  logic                     pc_write_cond,
  input  logic                     branch_taken,
  input  logic                     epc_write,
  input  logic                     err_clr,
  output logic [WIDTH-1:0]         pc_out,
  output logic [WIDTH-1:0]         next_pc,
  output logic [WIDTH-1:0]         epc_out,
  output logic                     align_exc,
  output logic [WIDTH-1:0]         bad_addr,
  output logic                     sel_err,
  output logic [CNT_W-1:0]         upd_cnt
);

  // A zero mask makes every target count as aligned when ALIGN_BITS is 0.
  localparam logic [WIDTH-1:0] ALIGN_MASK =
    (ALIGN_BITS == 0) ? '0 : WIDTH'((64'd1 << ALIGN_BITS) - 64'd1);

  logic wr_req;
  logic sel_ok;
  logic aligned;

  always_comb begin
    next_pc = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (32'(pc_src) == i) next_pc = src_data[i*WIDTH +: WIDTH];
    end
  end

  assign wr_req  = pc_write | (pc_write_cond & branch_taken);
  assign sel_ok  = (32'(pc_src) < 32'(NUM_SRC));
  assign aligned = ((next_pc & ALIGN_MASK) == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_out    <= RESET_PC;
      epc_out   <= '0;
      bad_addr  <= '0;
      upd_cnt   <= '0;
      align_exc <= 1'b0;
      sel_err   <= 1'b0;
    end else begin
      align_exc <= 1'b0;
      // EPC always samples the pre-edge PC, even when the PC is written this cycle.
      if (epc_write) epc_out <= pc_out - EPC_OFFSET;
      if (wr_req && sel_ok && aligned) begin
        pc_out  <= next_pc;
        upd_cnt <= upd_cnt + CNT_W'(1);
      end
      if (wr_req && sel_ok && !aligned) begin
        bad_addr  <= next_pc;
        align_exc <= 1'b1;
      end
      // A new bad select takes priority over a simultaneous clear.
      if (wr_req && !sel_ok) sel_err <= 1'b1;
      else if (err_clr)      sel_err <= 1'b0;
    end
  end

endmodule
